svm_coef_stream: RTL and testbench

Parametrised successor to the single-model SVM coefficient RAM that sits between the HOG feature path and the SVM classifier. It holds N_MODEL coefficient sets of N_FETCH wide words, each word being one ROW x COL block of COEF_W coefficients, plus one bias per model. A config port loads the sets. A request-driven sequencer streams one selected set to the classifier, one word per request, with a last-word flag.

---
 rtl/svm_coef_stream.sv | 126 ++++++++++++
 tb/tb_svm_coef_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_coef_stream.sv
// svm_coef_stream: multi-model SVM coefficient store with a request-driven word streamer.
// Define SVM_COEF_READBACK_EN to enable config-port readback via cfg_re/cfg_rdata.
module svm_coef_stream #(
    parameter int FEA_I = 4,
    parameter int FEA_F = 8,
    parameter int ROW = 15,
    parameter int COL = 7,
    parameter int N_FETCH = 36,
    parameter int N_MODEL = 2,
    localparam int COEF_W = FEA_I + FEA_F,
    localparam int RAM_DW = COEF_W * ROW * COL,
    localparam int ADDR_W = (N_FETCH > 1) ? $clog2(N_FETCH) : 1,
    localparam int MDL_W = (N_MODEL > 1) ? $clog2(N_MODEL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MDL_W-1:0]  cfg_model,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_we,
    input  logic [RAM_DW-1:0] cfg_wdata,
    input  logic              cfg_re,
    output logic [RAM_DW-1:0] cfg_rdata,
    output logic              cfg_err,
    input  logic [COEF_W-1:0] bias_in,
    input  logic              b_load,
    input  logic              start,
    input  logic [MDL_W-1:0]  mdl_sel,
    input  logic              request,
    output logic [RAM_DW-1:0] coef,
    output logic              coef_valid,
    output logic              coef_last,
    output logic [COEF_W-1:0] bias_out,
    output logic              busy
);
    localparam int DEPTH = N_MODEL * N_FETCH;
    localparam int PA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_FETCH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, READY, FETCH, DONE} state_t;

    state_t state, state_nxt;
    logic [RAM_DW-1:0] mem [DEPTH];
    logic [COEF_W-1:0] bias [N_MODEL];
    logic [MDL_W-1:0] model;
    logic [ADDR_W-1:0] cnt;
    logic addr_ok, cfg_mdl_ok, sel_ok, cfg_free, we_ok, bl_ok, take, re_err, err;
    logic [PA_W-1:0] pa_cfg, pa_str;

    assign busy = state != IDLE;
    assign addr_ok = {1'b0, cfg_addr} < (ADDR_W + 1)'(N_FETCH);
    assign cfg_mdl_ok = {1'b0, cfg_model} < (MDL_W + 1)'(N_MODEL);
    assign sel_ok = {1'b0, mdl_sel} < (MDL_W + 1)'(N_MODEL);
    // The model being streamed is locked against config writes until the stream ends.
    assign cfg_free = cfg_mdl_ok && !(busy && cfg_model == model);
    assign we_ok = cfg_we && addr_ok && cfg_free;
    assign bl_ok = b_load && cfg_free;
    assign take = state == IDLE && start && sel_ok;
    assign pa_cfg = PA_W'(cfg_model) * PA_W'(N_FETCH) + PA_W'(cfg_addr);
    assign pa_str = PA_W'(model) * PA_W'(N_FETCH) + PA_W'(cnt);
    assign err = (cfg_we && !(addr_ok && cfg_free)) || (b_load && !cfg_free) ||
                 (state == IDLE && start && !sel_ok) || re_err;

`ifdef SVM_COEF_READBACK_EN
    assign re_err = cfg_re && !(addr_ok && cfg_mdl_ok);
`else
    logic unused_re;
    assign unused_re = cfg_re;
    assign re_err = 1'b0;
    assign cfg_rdata = '0;
`endif

    always_ff @(posedge clk) begin
        state <= rst ? state_nxt : IDLE;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = take ? LOAD : IDLE;
            LOAD:    state_nxt = READY;
            READY:   state_nxt = request ? FETCH : READY;
            FETCH:   state_nxt = (cnt == LAST) ? DONE : READY;
            default: state_nxt = IDLE;
        endcase
    end

    // Read-before-write ordering gives old data on same-address collisions.
    always_ff @(posedge clk) begin
        if (we_ok) mem[pa_cfg] <= cfg_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            model <= '0;
            cnt <= '0;
            coef <= '0;
            coef_valid <= 1'b0;
            coef_last <= 1'b0;
            bias_out <= '0;
            cfg_err <= 1'b0;
            for (int i = 0; i < N_MODEL; i++) bias[i] <= '0;
`ifdef SVM_COEF_READBACK_EN
            cfg_rdata <= '0;
`endif
        end else begin
            coef_valid <= 1'b0;
            coef_last <= 1'b0;
            cfg_err <= err;
            if (take) begin
                model <= mdl_sel;
                cnt <= '0;
            end
            if (state == LOAD) bias_out <= bias[model];
            if (state == READY && request) begin
                coef <= mem[pa_str];
                coef_valid <= 1'b1;
                coef_last <= cnt == LAST;
            end
            if (state == FETCH && cnt != LAST) cnt <= cnt + 1'b1;
            if (bl_ok) bias[cfg_model] <= bias_in;
`ifdef SVM_COEF_READBACK_EN
            if (cfg_re && addr_ok && cfg_mdl_ok) cfg_rdata <= mem[pa_cfg];
`endif
        end
    end
endmodule

// File: tb/tb_svm_coef_stream.sv
// tb_svm_coef_stream: directed/random bench for svm_coef_stream against an array-based reference.
// Runs with three models so an out-of-range model index is representable.
module tb_svm_coef_stream;
    localparam int NM = 3;
    localparam int NF = 36;
    localparam int CW = 12;
    localparam int DW = 1260;
    localparam int MW = 2;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [MW-1:0] cfg_model = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic cfg_we = 1'b0;
    logic [DW-1:0] cfg_wdata = '0;
    logic cfg_re = 1'b0;
    logic [DW-1:0] cfg_rdata;
    logic cfg_err;
    logic [CW-1:0] bias_in = '0;
    logic b_load = 1'b0;
    logic start = 1'b0;
    logic [MW-1:0] mdl_sel = '0;
    logic request = 1'b0;
    logic [DW-1:0] coef;
    logic coef_valid, coef_last;
    logic [CW-1:0] bias_out;
    logic busy;

    always #5 clk = ~clk;

    svm_coef_stream #(.N_MODEL(NM)) dut (
        .clk(clk), .rst(rst), .cfg_model(cfg_model), .cfg_addr(cfg_addr), .cfg_we(cfg_we),
        .cfg_wdata(cfg_wdata), .cfg_re(cfg_re), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
        .bias_in(bias_in), .b_load(b_load), .start(start), .mdl_sel(mdl_sel),
        .request(request), .coef(coef), .coef_valid(coef_valid), .coef_last(coef_last),
        .bias_out(bias_out), .busy(busy)
    );

    int total = 0;
    int bad = 0;
    int active = -1;
    logic [DW-1:0] ref_mem [NM][NF];
    logic [CW-1:0] ref_bias [NM];
    logic [DW-1:0] pat, pat2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed(lo)=%h expected(lo)=%h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [CW-1:0] v);
        logic [DW-1:0] w = '0;
        for (int j = 0; j < DW / CW; j++) w = {w[DW-CW-1:0], v};
        return w;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w = '0;
        for (int j = 0; j < 40; j++) w = {w[DW-33:0], 32'($urandom)};
        return w;
    endfunction

    task automatic check_zero(input string tag);
        chkw({tag, "_coef"}, coef, '0);
        chk1({tag, "_valid"}, coef_valid, 1'b0);
        chk1({tag, "_last"}, coef_last, 1'b0);
        chkw({tag, "_bias"}, DW'(bias_out), '0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_err"}, cfg_err, 1'b0);
        chkw({tag, "_rdata"}, cfg_rdata, '0);
    endtask

    task automatic cfg_write(input int m, input int a, input logic [DW-1:0] d);
        bit ok;
        ok = a < NF && m < NM && m != active;
        cfg_model = MW'(m);
        cfg_addr = AW'(a);
        cfg_wdata = d;
        cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
        if (ok) ref_mem[m][a] = d;
        chk1("cfg_err_we", cfg_err, !ok);
    endtask

    task automatic bias_load(input int m, input logic [CW-1:0] v);
        bit ok;
        ok = m < NM && m != active;
        cfg_model = MW'(m);
        bias_in = v;
        b_load = 1'b1;
        tick;
        b_load = 1'b0;
        if (ok) ref_bias[m] = v;
        chk1("cfg_err_bias", cfg_err, !ok);
    endtask

    task automatic stream(input int m, input bit hold, input bit mid, input int abort_at);
        start = 1'b1;
        mdl_sel = MW'(m);
        tick;
        start = 1'b0;
        active = m;
        chk1("busy_start", busy, 1'b1);
        tick;
        chkw("bias_out", DW'(bias_out), DW'(ref_bias[m]));
        for (int k = 0; k < NF; k++) begin
            request = 1'b1;
            tick;
            if (!hold) request = 1'b0;
            chk1("coef_valid", coef_valid, 1'b1);
            chkw("coef", coef, ref_mem[m][k]);
            chk1("coef_last", coef_last, k == NF - 1);
            if (k == abort_at) begin
                request = 1'b0;
                rst = 1'b0;
                tick;
                rst = 1'b1;
                check_zero("abort");
                for (int i = 0; i < NM; i++) ref_bias[i] = '0;
                active = -1;
                return;
            end
            tick;
            chk1("valid_gap", coef_valid, 1'b0);
            chk1("busy_mid", busy, 1'b1);
            if (mid && k == 1) begin
                cfg_write(m, 3, rnd_word());
                cfg_write((m + 1) % NM, 3, rnd_word());
                bias_load(m, CW'($urandom));
                start = 1'b1;
                mdl_sel = MW'((m + 2) % NM);
                tick;
                start = 1'b0;
                chk1("start_ignored_busy", busy, 1'b1);
                chk1("start_ignored_err", cfg_err, 1'b0);
                chk1("start_ignored_valid", coef_valid, 1'b0);
                chkw("bias_stable", DW'(bias_out), DW'(ref_bias[m]));
            end
        end
        request = 1'b0;
        tick;
        active = -1;
        chk1("busy_end", busy, 1'b0);
        chkw("coef_hold", coef, ref_mem[m][NF-1]);
    endtask

    initial begin
        tick;
        tick;
        check_zero("reset");
        rst = 1'b1;
        tick;
        for (int i = 0; i < NM; i++) ref_bias[i] = '0;
        for (int k = 0; k < NF; k++) cfg_write(1, k, fill(CW'(k + 1)));
        bias_load(1, 12'hF80);
        for (int k = 0; k < NF; k++) cfg_write(0, k, rnd_word());
        for (int k = 0; k < NF; k++) cfg_write(2, k, rnd_word());
        bias_load(0, CW'($urandom));
        bias_load(2, CW'($urandom));
        stream(1, 1'b0, 1'b0, -1);
        stream(0, 1'b0, 1'b1, -1);
        stream(1, 1'b1, 1'b0, -1);
        cfg_write(0, NF, rnd_word());
        tick;
        chk1("err_pulse_end", cfg_err, 1'b0);
        cfg_write(3, 0, rnd_word());
        bias_load(3, CW'($urandom));
        start = 1'b1;
        mdl_sel = 2'd3;
        tick;
        start = 1'b0;
        chk1("bad_start_err", cfg_err, 1'b1);
        chk1("bad_start_busy", busy, 1'b0);
        tick;
        chk1("bad_start_busy2", busy, 1'b0);
        chk1("bad_start_err_end", cfg_err, 1'b0);
        request = 1'b1;
        repeat (4) begin
            tick;
            chk1("idle_request", coef_valid, 1'b0);
        end
        request = 1'b0;
        stream(2, 1'b0, 1'b0, 10);
        stream(2, 1'b0, 1'b0, -1);
`ifdef SVM_COEF_READBACK_EN
        pat = fill(12'hABC);
        cfg_write(0, 5, pat);
        cfg_model = '0;
        cfg_addr = 6'd5;
        cfg_re = 1'b1;
        tick;
        cfg_re = 1'b0;
        chkw("rdata", cfg_rdata, pat);
        tick;
        chkw("rdata_hold", cfg_rdata, pat);
        pat2 = rnd_word();
        cfg_wdata = pat2;
        cfg_we = 1'b1;
        cfg_re = 1'b1;
        tick;
        cfg_we = 1'b0;
        cfg_re = 1'b0;
        ref_mem[0][5] = pat2;
        chkw("rdata_old", cfg_rdata, pat);
        cfg_re = 1'b1;
        tick;
        cfg_re = 1'b0;
        chkw("rdata_new", cfg_rdata, ref_mem[0][5]);
        cfg_addr = AW'(NF);
        cfg_re = 1'b1;
        tick;
        cfg_re = 1'b0;
        chk1("rdata_bad_err", cfg_err, 1'b1);
        chkw("rdata_bad_keep", cfg_rdata, pat2);
`else
        cfg_model = '0;
        cfg_addr = 6'd5;
        cfg_re = 1'b1;
        tick;
        cfg_re = 1'b0;
        chkw("rdata_off", cfg_rdata, '0);
        chk1("rdata_off_err", cfg_err, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
